// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// grant codes and the data word returned to a master on a watchdog abort.
package wb_arb_pkg;

    // State codes double as the one-hot grant vector (bit n = master n owns).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Abort read data; wide enough for any practical bus, sliced by the user.
    localparam int                      MAX_DATA_WIDTH = 256;
    localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Wait-state watchdog: counts cycles an owner strobes without an ack and
// raises a one-cycle abort after TIMEOUT_CYCLES such cycles.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,   // owner holds cyc & stb and the bus is granted
    input  logic ack_i,      // slave ack for the current beat
    output logic abort_o     // abort cycle in progress
);

    // A zero timeout disables the watchdog; keep at least one counter bit.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          abort_q;

    // Wait-state counter with saturation and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else if (abort_q || !active_i || ack_i) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == LIMIT) begin
            cnt_q   <= '0;
            abort_q <= 1'b1;
        end else begin
            abort_q <= 1'b0;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign abort_o = abort_q;

endmodule

// File: rtl/wishbone_master_arbiter.sv
// Two-master to one-slave Wishbone arbiter: per-cycle locked grant,
// round-robin on ties, watchdog abort of hung transfers.
module wishbone_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_int_o,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_int_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [3:0]            s_sel_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_int_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    state_e state_q;
    logic   last_owner_q;   // 1 after reset so master 0 wins the first tie
    logic   abort;

    logic   own_cyc;
    logic   own_stb;
    logic   own_ack;
    logic [DATA_WIDTH-1:0] own_dat;

    // Ownership FSM: grant held for the whole cyc, handover without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_q <= last_owner_q ? ST_OWN0 : ST_OWN1;
                    end else if (m0_cyc_i) begin
                        state_q <= ST_OWN0;
                    end else if (m1_cyc_i) begin
                        state_q <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if (!m0_cyc_i) begin
                        last_owner_q <= 1'b0;
                        state_q      <= m1_cyc_i ? ST_OWN1 : ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    if (!m1_cyc_i) begin
                        last_owner_q <= 1'b1;
                        state_q      <= m0_cyc_i ? ST_OWN0 : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Route the owner's request to the slave port; idle drives zeros.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (state_q == ST_OWN0) begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (state_q == ST_OWN1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // The abort cycle masks the slave handshake and substitutes its own reply.
    assign s_cyc_o = own_cyc & ~abort;
    assign s_stb_o = own_stb & ~abort;
    assign own_ack = abort ? 1'b1 : s_ack_i;
    assign own_dat = abort ? TIMEOUT_DATA[DATA_WIDTH-1:0] : s_dat_i;

    assign m0_ack_o = (state_q == ST_OWN0) ? own_ack : 1'b0;
    assign m0_dat_o = (state_q == ST_OWN0) ? own_dat : '0;
    assign m1_ack_o = (state_q == ST_OWN1) ? own_ack : 1'b0;
    assign m1_dat_o = (state_q == ST_OWN1) ? own_dat : '0;

    assign m0_int_o  = s_int_i;
    assign m1_int_o  = s_int_i;
    assign grant_o   = state_q;
    assign timeout_o = abort;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i ((state_q != ST_IDLE) & own_cyc & own_stb),
        .ack_i    (s_ack_i),
        .abort_o  (abort)
    );

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Directed bench for wishbone_master_arbiter: arbitration, locking,
// round-robin, watchdog abort (timeout 4 and disabled) and mid-transfer reset.
module tb_wishbone_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [3:0]    m0_sel, m1_sel;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_int;

    // Outputs of the instance with TIMEOUT_CYCLES = 4
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m1_ack_o, m0_int_o, m1_int_o;
    logic          s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [1:0]    grant_o;

    // Outputs of the instance with the watchdog disabled
    logic [DW-1:0] n_m0_dat_o, n_m1_dat_o, n_s_dat_o;
    logic          n_m0_ack_o, n_m1_ack_o, n_m0_int_o, n_m1_int_o;
    logic          n_s_we_o, n_s_cyc_o, n_s_stb_o, n_timeout_o;
    logic [3:0]    n_s_sel_o;
    logic [AW-1:0] n_s_adr_o;
    logic [1:0]    n_grant_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wishbone_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_int_o(m0_int_o),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_int_o(m1_int_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .s_int_i(s_int), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wishbone_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk(clk), .rst(rst),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(n_m0_dat_o), .m0_ack_o(n_m0_ack_o),
        .m0_int_o(n_m0_int_o),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(n_m1_dat_o), .m1_ack_o(n_m1_ack_o),
        .m1_int_o(n_m1_int_o),
        .s_we_o(n_s_we_o), .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o), .s_sel_o(n_s_sel_o),
        .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .s_int_i(s_int), .grant_o(n_grant_o), .timeout_o(n_timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; callers drive, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_we = 0; m0_cyc = 0; m0_stb = 0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
        m1_we = 0; m1_cyc = 0; m1_stb = 0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
        s_rdat = '0; s_ack = 0; s_int = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    int pulses;
    int n_pulses;

    initial begin
        rst = 1;
        idle_inputs();
        do_reset();
        settle();

        // ---- reset state
        check("rst_grant", grant_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_s_stb", s_stb_o, 0);
        check("rst_m0_ack", m0_ack_o, 0);
        check("rst_m0_dat", m0_dat_o, 0);
        check("rst_timeout", timeout_o, 0);

        // ---- interrupt broadcast
        s_int = 1; settle();
        check("int_m0", m0_int_o, 1);
        check("int_m1", m1_int_o, 1);
        s_int = 0;

        // ---- single master read, 2 wait states
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0001; m0_sel = 4'hF; settle();
        check("single_grant_lat", grant_o, 2'b00);
        tick(); settle();
        check("single_grant", grant_o, 2'b01);
        check("single_s_adr", s_adr_o, 32'h0000_0001);
        check("single_s_stb", s_stb_o, 1);
        check("single_ack_wait1", m0_ack_o, 0);
        tick(); settle();
        check("single_ack_wait2", m0_ack_o, 0);
        tick();
        s_ack = 1; s_rdat = 32'h0123_4567; settle();
        check("single_m0_ack", m0_ack_o, 1);
        check("single_m0_dat", m0_dat_o, 32'h0123_4567);
        check("single_m1_ack", m1_ack_o, 0);
        check("single_m1_dat", m1_dat_o, 0);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0; s_rdat = '0; settle();
        tick(); settle();
        check("single_release", grant_o, 2'b00);

        // ---- simultaneous request right after reset: m0 first, then m1 no bubble
        do_reset();
        m0_cyc = 1; m1_cyc = 1; settle();
        tick(); settle();
        check("tie_first_m0", grant_o, 2'b01);
        m0_cyc = 0;
        tick(); settle();
        check("handover_m1", grant_o, 2'b10);
        m1_cyc = 0;
        tick(); settle();
        check("m1_release_idle", grant_o, 2'b00);

        // ---- round robin: last owner m1 -> tie goes to m0
        m0_cyc = 1; m1_cyc = 1;
        tick(); settle();
        check("rr_after_m1", grant_o, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        tick(); settle();
        check("rr_idle", grant_o, 2'b00);
        // last owner m0 -> tie goes to m1
        m0_cyc = 1; m1_cyc = 1;
        tick(); settle();
        check("rr_after_m0", grant_o, 2'b10);

        // ---- locked burst: m1 keeps cyc for 3 beats while m0 waits
        for (int b = 0; b < 3; b++) begin
            m1_stb = 1; m1_adr = 32'h100 + b; s_ack = 1; s_rdat = 32'hA0 + b;
            settle();
            check($sformatf("burst%0d_grant", b), grant_o, 2'b10);
            check($sformatf("burst%0d_adr", b), s_adr_o, 32'h100 + b);
            check($sformatf("burst%0d_m1_ack", b), m1_ack_o, 1);
            check($sformatf("burst%0d_m1_dat", b), m1_dat_o, 32'hA0 + b);
            check($sformatf("burst%0d_m0_ack", b), m0_ack_o, 0);
            tick();
        end
        m1_stb = 0; m1_cyc = 0; s_ack = 0; s_rdat = '0;
        tick(); settle();
        check("burst_then_m0", grant_o, 2'b01);

        // ---- watchdog, timeout 4: slave never acks (late ack in abort cycle)
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        tick();                 // cycle 0 of ownership
        pulses = 0;
        n_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                s_ack = 1; s_rdat = 32'h1234_5678;
            end else if (i == 6) begin
                s_ack = 0; s_rdat = '0; m0_cyc = 0; m0_stb = 0;
            end
            settle();
            check($sformatf("wd_c%0d_timeout", i), timeout_o, (i == 5));
            check($sformatf("wd_c%0d_m0_ack", i), m0_ack_o, (i == 5));
            if (timeout_o) pulses++;
            if (n_timeout_o) n_pulses++;
            if (i == 5) begin
                check("wd_abort_dat", m0_dat_o, 32'hFFFF_FFFF);
                check("wd_abort_stb", s_stb_o, 0);
                check("wd_abort_cyc", s_cyc_o, 0);
                check("wd_abort_grant", grant_o, 2'b01);
            end
            tick();
        end
        check("wd_pulse_count", pulses, 1);

        // ---- watchdog disabled: hold a hung strobe for 1000 cycles
        m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (n_timeout_o || n_m0_ack_o) n_pulses++;
        end
        check("nowd_aborts", n_pulses, 0);
        check("nowd_grant", n_grant_o, 2'b01);

        // ---- reset mid-transfer in OWN1
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h80;
        tick(); settle();
        check("midrst_own1", grant_o, 2'b10);
        rst = 1;
        tick(); settle();
        check("midrst_grant", grant_o, 2'b00);
        check("midrst_s_cyc", s_cyc_o, 0);
        check("midrst_m1_ack", m1_ack_o, 0);
        rst = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick(); settle();
        check("midrst_tie_m0", grant_o, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
